// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: increment, re-fetch, relative branch,
// absolute jump, interrupt vector, or multi-beat return address assembled from data memory.
module pc_sequencer #(
    parameter int unsigned       PC_W       = 32,
    parameter int unsigned       DATA_W     = 16,
    parameter logic [PC_W-1:0]   RESET_VEC  = PC_W'(32),
    parameter logic [PC_W-1:0]   INT_VEC    = '0,
    parameter bit                REL_SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        pc_src,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              int_req,
    input  logic              ret_start,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_valid,
    output logic [PC_W-1:0]   pc,
    output logic              ret_busy,
    output logic              int_ack
);

    localparam int unsigned BEATS = PC_W / DATA_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        RET_LOAD = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [PC_W-1:0]   pc_n;
    logic [PC_W-1:0]   ret_buf, ret_buf_n;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_n;
    logic              int_ack_n;
    logic [PC_W-1:0]   rel_ext;
    logic [PC_W-1:0]   ret_shift;

    assign rel_ext   = REL_SIGNED ? PC_W'($signed(alu_out)) : PC_W'(alu_out);
    // Truncating the concatenation drops the oldest word; with BEATS==1 this is just mem_data.
    assign ret_shift = PC_W'({ret_buf, mem_data});

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_VEC;
            ret_buf  <= '0;
            beat_cnt <= '0;
            int_ack  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ret_buf  <= ret_buf_n;
            beat_cnt <= beat_cnt_n;
            int_ack  <= int_ack_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ret_buf_n  = ret_buf;
        beat_cnt_n = beat_cnt;
        int_ack_n  = 1'b0;
        if (int_req) begin
            // Interrupt wins in either state and discards any partial return address.
            state_n    = RUN;
            pc_n       = INT_VEC;
            ret_buf_n  = '0;
            beat_cnt_n = '0;
            int_ack_n  = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (ret_start) begin
                        state_n    = RET_LOAD;
                        beat_cnt_n = '0;
                        ret_buf_n  = '0;
                    end else if (!stall) begin
                        unique case (pc_src)
                            2'b00: pc_n = pc + 1'b1;
                            2'b01: pc_n = pc + rel_ext;
                            2'b10: pc_n = pc - 1'b1;
                            2'b11: pc_n = PC_W'(alu_out);
                        endcase
                    end
                end
                RET_LOAD: begin
                    if (mem_valid) begin
                        if (beat_cnt == CNT_W'(BEATS - 1)) begin
                            pc_n       = ret_shift;
                            state_n    = RUN;
                            beat_cnt_n = '0;
                        end else begin
                            ret_buf_n  = ret_shift;
                            beat_cnt_n = beat_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ret_busy = (state == RET_LOAD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expectations, a monitor checks each cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [15:0] alu_out = '0;
    logic        int_req = 1'b0;
    logic        ret_start = 1'b0;
    logic [15:0] mem_data = '0;
    logic        mem_valid = 1'b0;
    logic [31:0] pc, pc_u;
    logic        ret_busy, int_ack, ret_busy_u, int_ack_u;

    typedef struct {
        logic [31:0] pc;
        logic        busy;
        logic        ack;
        logic [31:0] pc_u;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(32), .DATA_W(16), .RESET_VEC(32'd32), .INT_VEC(32'd0), .REL_SIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .alu_out(alu_out),
        .int_req(int_req), .ret_start(ret_start), .mem_data(mem_data), .mem_valid(mem_valid),
        .pc(pc), .ret_busy(ret_busy), .int_ack(int_ack)
    );

    pc_sequencer #(.PC_W(32), .DATA_W(16), .RESET_VEC(32'd32), .INT_VEC(32'd0), .REL_SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .alu_out(alu_out),
        .int_req(int_req), .ret_start(ret_start), .mem_data(mem_data), .mem_valid(mem_valid),
        .pc(pc_u), .ret_busy(ret_busy_u), .int_ack(int_ack_u)
    );

    // Monitor: every cycle the DUT presents a registered result one delta after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                vectors++;
                if (pc !== e.pc) begin
                    miscompares++;
                    $display("FAIL pc vec%0d: got %h expected %h", vectors, pc, e.pc);
                end
                if (ret_busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL ret_busy vec%0d: got %b expected %b", vectors, ret_busy, e.busy);
                end
                if (int_ack !== e.ack) begin
                    miscompares++;
                    $display("FAIL int_ack vec%0d: got %b expected %b", vectors, int_ack, e.ack);
                end
                if (pc_u !== e.pc_u) begin
                    miscompares++;
                    $display("FAIL pc_unsigned vec%0d: got %h expected %h", vectors, pc_u, e.pc_u);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic stl, input logic [1:0] src,
                        input logic [15:0] alu, input logic irq, input logic rs,
                        input logic [15:0] md, input logic mv,
                        input logic [31:0] epc, input logic eb, input logic ea,
                        input logic [31:0] epc_u);
        exp_t e;
        @(negedge clk);
        reset = rst; stall = stl; pc_src = src; alu_out = alu;
        int_req = irq; ret_start = rs; mem_data = md; mem_valid = mv;
        e.pc = epc; e.busy = eb; e.ack = ea; e.pc_u = epc_u;
        q.push_back(e);
    endtask

    // Same expected pc for both instances.
    task automatic s(input logic rst, input logic stl, input logic [1:0] src,
                     input logic [15:0] alu, input logic irq, input logic rs,
                     input logic [15:0] md, input logic mv,
                     input logic [31:0] epc, input logic eb, input logic ea);
        step(rst, stl, src, alu, irq, rs, md, mv, epc, eb, ea, epc);
    endtask

    initial begin
        // rst stl src   alu       irq rs md        mv  pc            busy ack
        s(1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd32,       0, 0);
        s(1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd32,       0, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd33,       0, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd34,       0, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd35,       0, 0);
        // absolute jump to 100, then relative -4 (signed) vs +65532 (unsigned)
        s(0, 0, 2'b11, 16'd100,  0, 0, 16'h0000, 0, 32'd100,      0, 0);
        step(0, 0, 2'b01, 16'hFFFC, 0, 0, 16'h0000, 0, 32'd96, 0, 0, 32'd65632);
        s(1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd32,       0, 0);
        // wrap-around at both ends
        s(0, 0, 2'b11, 16'h0000, 0, 0, 16'h0000, 0, 32'd0,        0, 0);
        s(0, 0, 2'b10, 16'h0000, 0, 0, 16'h0000, 0, 32'hFFFF_FFFF, 0, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd0,        0, 0);
        s(0, 0, 2'b10, 16'h0000, 0, 0, 16'h0000, 0, 32'hFFFF_FFFF, 0, 0);
        s(0, 0, 2'b11, 16'h0040, 0, 0, 16'h0000, 0, 32'd64,       0, 0);
        // return load with stall asserted at start, gaps between beats
        s(0, 1, 2'b00, 16'h0000, 0, 1, 16'h0000, 0, 32'd64,       1, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0001, 1, 32'd64,       1, 0);
        s(0, 0, 2'b01, 16'h0007, 0, 0, 16'h0000, 0, 32'd64,       1, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 1, 16'h0000, 0, 32'd64,       1, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h2345, 1, 32'h0001_2345, 0, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'h0001_2346, 0, 0);
        // interrupt aborts a partial return load
        s(0, 0, 2'b00, 16'h0000, 0, 1, 16'h0000, 0, 32'h0001_2346, 1, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'hAAAA, 1, 32'h0001_2346, 1, 0);
        s(0, 0, 2'b00, 16'h0000, 1, 0, 16'hBBBB, 1, 32'd0,        0, 1);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h5555, 1, 32'd1,        0, 0);
        // held interrupt re-vectors each cycle
        s(0, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 0, 32'd0,        0, 1);
        s(0, 0, 2'b00, 16'h0000, 1, 0, 16'h0000, 0, 32'd0,        0, 1);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd1,        0, 0);
        // interrupt beats ret_start on the same edge
        s(0, 0, 2'b00, 16'h0000, 1, 1, 16'h0000, 0, 32'd0,        0, 1);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd1,        0, 0);
        // stall holds pc for three cycles
        s(0, 1, 2'b01, 16'h0005, 0, 0, 16'h0000, 0, 32'd1,        0, 0);
        s(0, 1, 2'b01, 16'h0005, 0, 0, 16'h0000, 0, 32'd1,        0, 0);
        s(0, 1, 2'b01, 16'h0005, 0, 0, 16'h0000, 0, 32'd1,        0, 0);
        s(0, 0, 2'b01, 16'h0005, 0, 0, 16'h0000, 0, 32'd6,        0, 0);
        // reset in the middle of a return load
        s(0, 0, 2'b00, 16'h0000, 0, 1, 16'h0000, 0, 32'd6,        1, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h1234, 1, 32'd6,        1, 0);
        s(1, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 0, 32'd32,       0, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0000, 1, 32'd33,       0, 0);
        // fresh load after reset assembles only its own beats
        s(0, 0, 2'b00, 16'h0000, 0, 1, 16'h0000, 0, 32'd33,       1, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'hBEEF, 1, 32'd33,       1, 0);
        s(0, 0, 2'b00, 16'h0000, 0, 0, 16'h0001, 1, 32'hBEEF_0001, 0, 0);

        @(negedge clk);
        mem_valid = 1'b0; ret_start = 1'b0; int_req = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
